// File: rtl/uart_mmio_responder_if.sv
// rtl/uart_mmio_responder_if.sv - CPU memory-stage data port between the MEMORY stage and the UART responder
interface uart_mmio_responder_if;
  logic        write;
  logic [1:0]  area;
  logic [31:0] address;
  logic [31:0] datain;
  logic [31:0] dataout;

  modport master (output write, area, address, datain, input dataout);
  modport slave  (input write, area, address, datain, output dataout);
endinterface

// File: rtl/uart_mmio_responder.sv
// rtl/uart_mmio_responder.sv - memory-mapped UART transmitter with TX FIFO; define UART_PARITY_EN for an even-parity bit
module uart_mmio_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_mmio_responder_if.slave bus,
  output logic                 tx
);

  localparam int            AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   HALF_C  = (AW+1)'(FIFO_DEPTH / 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // register window decode uses the word address only
  logic sel_data, sel_status, sel_div;
  assign sel_data   = (bus.address[31:2] == BASE_ADDR[31:2]);
  assign sel_status = (bus.address[31:2] == BASE_ADDR[31:2] + 30'd1);
  assign sel_div    = (bus.address[31:2] == BASE_ADDR[31:2] + 30'd2);

  logic unused_bits;
  assign unused_bits = ^{bus.address[1:0], bus.datain[31:16]};

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [15:0]   div_reg;
  logic          fifo_empty, fifo_full, push_req, push, pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign push_req   = bus.write && sel_data;
  // a store into a full FIFO is dropped even if the transmitter pops on the same edge
  assign push       = push_req && !fifo_full;

  state_t      state, state_n;
  logic [15:0] baudcnt, baud_n;
  logic [2:0]  bitcnt, bit_n;
  logic [7:0]  shift, shift_n;
  logic        tx_q, tx_n;
  logic [15:0] div_eff, reload;

  assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;
  assign reload  = div_eff - 16'd1;
  assign tx      = tx_q;

  // FIFO storage; not reset, only the pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.datain[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push_req && fifo_full)       ovf <= 1'b1;
      else if (bus.write && sel_status) ovf <= 1'b0;
    end
  end

  // baud divisor; a byte store only touches the low byte
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= DEFAULT_DIV;
    end else if (bus.write && sel_div) begin
      if (bus.area == 2'b00) div_reg[7:0] <= bus.datain[7:0];
      else                   div_reg      <= bus.datain[15:0];
    end
  end

  // transmitter state and registered serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      baudcnt <= 16'd0;
      bitcnt  <= 3'd0;
      shift   <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baudcnt <= baud_n;
      bitcnt  <= bit_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
    end
  end

  // next-state logic; STOP expiry with data pending chains straight into a new START
  always_comb begin
    state_n = state;
    baud_n  = baudcnt;
    bit_n   = bitcnt;
    shift_n = shift;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = reload;
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (baudcnt == 16'd0) begin
          state_n = S_DATA;
          tx_n    = shift[0];
          bit_n   = 3'd0;
          baud_n  = reload;
        end else begin
          baud_n = baudcnt - 16'd1;
        end
      end
      S_DATA: begin
        if (baudcnt == 16'd0) begin
          baud_n = reload;
          if (bitcnt == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = S_PARITY;
            tx_n    = ^shift;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bitcnt + 3'd1;
            tx_n  = shift[bit_n];
          end
        end else begin
          baud_n = baudcnt - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baudcnt == 16'd0) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
          baud_n  = reload;
        end else begin
          baud_n = baudcnt - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baudcnt == 16'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            baud_n  = reload;
            tx_n    = 1'b0;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baudcnt - 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // load data mux; DATA and unmapped addresses read as zero
  always_comb begin
    bus.dataout = 32'd0;
    if (sel_status)
      bus.dataout = {26'd0, (count > HALF_C), ovf, fifo_empty, fifo_full, (state != S_IDLE)};
    else if (sel_div)
      bus.dataout = {16'd0, div_reg};
  end

endmodule
